// File: rtl/conv_frame_ctrl_pkg.sv
// conv_pkg: shared state encoding, default pixel width and counter-width helper
// for the conv_frame_ctrl frame sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    DRAIN
  } conv_state_e;

  localparam int PIX_W_DEF = 4;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if: upstream (s_*) and downstream (m_*) pixel streams of the
// frame sequencer. The master modport is the sequencer's view, slave is the
// surrounding system's view.
interface conv_frame_ctrl_if #(
  parameter int PIX_W = conv_pkg::PIX_W_DEF
);
  logic [PIX_W-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_sof, m_eol, m_eof
  );

  modport slave (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_sof, m_eol, m_eof
  );
endinterface

// File: rtl/conv_frame_ctrl_pos_counter.sv
// conv_pos_counter: position counter advancing once per enable. Tracks a column
// that wraps at W-1, a row that advances on each wrap, and a plain linear index.
// i_clr holds the counter at zero.
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int W     = 640,
  parameter int H     = 480,
  parameter int LIN_N = H * W + W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_en,
  output logic [cnt_w(W)-1:0]       o_col,
  output logic [cnt_w(H+2)-1:0]     o_row,
  output logic [cnt_w(LIN_N)-1:0]   o_lin,
  output logic                      o_col_last,
  output logic                      o_row_last
);
  localparam int CW = cnt_w(W);
  localparam int RW = cnt_w(H + 2);
  localparam int LW = cnt_w(LIN_N);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [LW-1:0] r_lin;
  logic          w_col_last;

  assign w_col_last = (r_col == CW'(W - 1));

  // Advance column/row/linear position on each enabled step.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_col <= '0;
      r_row <= '0;
      r_lin <= '0;
    end else if (i_en) begin
      r_lin <= r_lin + 1'b1;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_lin      = r_lin;
  assign o_col_last = w_col_last;
  assign o_row_last = (r_row == RW'(H - 1));
endmodule

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer for the streaming 3x3 blur filter.
// Accepts one frame of pixels, steps the filter, injects IMG_W+1 zero flush
// pixels at frame end and registers the filter output into a downstream
// stream tagged with SOF/EOL/EOF.
// Optional feature macro: CONV_FRAME_CNT_EN enables the completed-frame counter.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  conv_frame_ctrl_if.master   bus,
  output logic [PIX_W-1:0]    o_filt_pixel_in,
  output logic                o_filt_en,
  output logic                o_filt_rst,
  input  logic [PIX_W-1:0]    i_filt_pixel_out,
  output logic [15:0]         o_frame_cnt
);
  localparam int LIN_N = IMG_H * IMG_W + IMG_W + 1;
  localparam int LW    = cnt_w(LIN_N);
  localparam int CW    = cnt_w(IMG_W);
  localparam int RW    = cnt_w(IMG_H + 2);

  // Step index thresholds: first step with a valid window centre, last real
  // input, last flush injection.
  localparam logic [LW-1:0] L_PEND       = LW'(IMG_W + 1);
  localparam logic [LW-1:0] L_RUN_LAST   = LW'(IMG_H * IMG_W - 1);
  localparam logic [LW-1:0] L_FLUSH_LAST = LW'(IMG_H * IMG_W + IMG_W);

  conv_state_e      r_state;
  logic             r_pend;
  logic             r_m_valid;
  logic [PIX_W-1:0] r_m_data;
  logic             r_sof;
  logic             r_eol;
  logic             r_eof;
  logic             r_done;
  logic             r_filt_rst;

  logic             w_stall;
  logic             w_s_ready;
  logic             w_filt_en;
  logic             w_capture;
  logic             w_pend_set;
  logic             w_idle;

  logic [CW-1:0]    w_in_col;
  logic [RW-1:0]    w_in_row;
  logic [LW-1:0]    w_in_lin;
  logic             w_in_col_last;
  logic             w_in_row_last;
  logic [CW-1:0]    w_out_col;
  logic [RW-1:0]    w_out_row;
  logic [LW-1:0]    w_out_lin;
  logic             w_out_col_last;
  logic             w_out_row_last;
  logic             w_unused;

  // A pending result that cannot leave the output register blocks the filter.
  assign w_stall    = r_pend & r_m_valid & ~bus.m_ready;
  assign w_s_ready  = (r_state == RUN) & ~w_stall;
  assign w_filt_en  = (r_state == RUN)   ? (bus.s_valid & w_s_ready) :
                      (r_state == FLUSH) ? ~w_stall : 1'b0;
  assign w_capture  = r_pend & (~r_m_valid | bus.m_ready);
  assign w_pend_set = w_filt_en & (w_in_lin >= L_PEND);
  assign w_idle     = (r_state == IDLE);

  conv_pos_counter #(.W(IMG_W), .H(IMG_H), .LIN_N(LIN_N)) u_in_pos (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_idle),
    .i_en       (w_filt_en),
    .o_col      (w_in_col),
    .o_row      (w_in_row),
    .o_lin      (w_in_lin),
    .o_col_last (w_in_col_last),
    .o_row_last (w_in_row_last)
  );

  conv_pos_counter #(.W(IMG_W), .H(IMG_H), .LIN_N(LIN_N)) u_out_pos (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_idle),
    .i_en       (w_capture),
    .o_col      (w_out_col),
    .o_row      (w_out_row),
    .o_lin      (w_out_lin),
    .o_col_last (w_out_col_last),
    .o_row_last (w_out_row_last)
  );

  // Input-side position is only needed as a linear index.
  assign w_unused = ^{w_in_col, w_in_row, w_in_col_last, w_in_row_last, w_out_lin};

  // Frame FSM plus pending-result tracking and downstream output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_sof      <= 1'b0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_done     <= 1'b0;
      r_filt_rst <= 1'b1;
    end else begin
      r_done     <= 1'b0;
      r_filt_rst <= 1'b0;
      r_pend     <= w_pend_set | (r_pend & ~w_capture);

      if (w_capture) begin
        r_m_valid <= 1'b1;
        r_m_data  <= i_filt_pixel_out;
        r_sof     <= (w_out_col == '0) && (w_out_row == '0);
        r_eol     <= w_out_col_last;
        r_eof     <= w_out_col_last & w_out_row_last;
      end else if (r_m_valid && bus.m_ready) begin
        r_m_valid <= 1'b0;
        r_sof     <= 1'b0;
        r_eol     <= 1'b0;
        r_eof     <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state    <= CLEAR;
            r_filt_rst <= 1'b1;
          end
        end
        CLEAR: r_state <= RUN;
        RUN: begin
          if (w_filt_en && (w_in_lin == L_RUN_LAST)) r_state <= FLUSH;
        end
        FLUSH: begin
          if (w_filt_en && (w_in_lin == L_FLUSH_LAST)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!r_pend && r_m_valid && bus.m_ready && r_eof) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CONV_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count completed frames, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) r_frame_cnt <= '0;
    else if (r_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign o_frame_cnt = r_frame_cnt;
`else
  assign o_frame_cnt = '0;
`endif

  assign o_busy          = (r_state != IDLE);
  assign o_done          = r_done;
  assign o_filt_rst      = r_filt_rst;
  assign o_filt_en       = w_filt_en;
  assign o_filt_pixel_in = (r_state == RUN) ? bus.s_data : '0;
  assign bus.s_ready     = w_s_ready;
  assign bus.m_data      = r_m_data;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_sof       = r_sof;
  assign bus.m_eol       = r_eol;
  assign bus.m_eof       = r_eof;
endmodule
